// File: rtl/riscv_trace_buffer.sv
`default_nettype none
// ============================================================================
// riscv_trace_buffer : retire-trace capture FIFO with optional PC trigger
// Revision 1.0
// ============================================================================
module riscv_trace_buffer #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int WRAP      = 0,
  parameter int FILTER_X0 = 1
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       update_i,
  input  logic [XLEN-1:0]            pc_i,
  input  logic [31:0]                instr_i,
  input  logic [4:0]                 reg_addr_i,
  input  logic [XLEN-1:0]            reg_data_i,
  input  logic                       mem_we_i,
  input  logic [XLEN-1:0]            mem_addr_i,
  input  logic [XLEN-1:0]            mem_data_i,
  input  logic                       enable_i,
  input  logic                       clear_i,
  input  logic                       trig_en_i,
  input  logic [XLEN-1:0]            trig_pc_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [XLEN-1:0]            out_pc_o,
  output logic [31:0]                out_instr_o,
  output logic [XLEN-1:0]            out_rd_data_o,
  output logic [XLEN-1:0]            out_mem_addr_o,
  output logic [XLEN-1:0]            out_mem_data_o,
  output logic [4:0]                 out_rd_o,
  output logic                       out_has_rd_o,
  output logic                       out_mem_we_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [15:0]                drop_cnt_o,
  output logic [63:0]                instret_o,
  output logic [1:0]                 state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam bit WRAP_EN = (WRAP != 0);
  localparam bit FILT_EN = (FILTER_X0 != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   wp_q, rp_q;
  logic [CW-1:0]   count_q;
  logic [15:0]     drop_q;
  logic [63:0]     instret_q;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic [4:0]      rd_mem    [DEPTH];
  logic [XLEN-1:0] rdd_mem   [DEPTH];
  logic            hasrd_mem [DEPTH];
  logic            mwe_mem   [DEPTH];
  logic [XLEN-1:0] maddr_mem [DEPTH];
  logic [XLEN-1:0] mdata_mem [DEPTH];

  logic w_trig_hit, w_push_req, w_push, w_pop, w_full, w_wr_en, w_drop, w_has_rd;

  assign w_trig_hit = update_i && (pc_i == trig_pc_i);
  // Disabling in ARMED/CAPTURE discards the retire of that same cycle.
  assign w_push_req = enable_i &&
                      (((state_q == CAPTURE) && update_i) ||
                       ((state_q == ARMED) && w_trig_hit));
  assign w_push  = w_push_req && !clear_i;
  assign w_pop   = (count_q != '0) && out_ready_i && !clear_i;
  assign w_full  = (count_q == FULL_CNT);
  assign w_drop  = w_push && w_full && !w_pop;
  assign w_wr_en = w_push && (!w_full || w_pop || WRAP_EN);
  assign w_has_rd = (reg_addr_i != 5'd0);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      wp_q      <= '0;
      rp_q      <= '0;
      count_q   <= '0;
      drop_q    <= '0;
      instret_q <= '0;
    end else begin
      if (update_i) instret_q <= instret_q + 64'd1;

      case (state_q)
        IDLE:    if (enable_i) state_q <= trig_en_i ? ARMED : CAPTURE;
        ARMED:   if (!enable_i) state_q <= IDLE;
                 else if (w_trig_hit) state_q <= CAPTURE;
        CAPTURE: if (!enable_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (clear_i) begin
        wp_q    <= '0;
        rp_q    <= '0;
        count_q <= '0;
        drop_q  <= '0;
      end else begin
        if (w_wr_en) wp_q <= wp_q + AW'(1);
        // In wrap mode an overflowing push evicts the oldest entry.
        if (w_pop || (w_drop && WRAP_EN)) rp_q <= rp_q + AW'(1);
        if (w_drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
        if (w_push && !w_full && !w_pop) count_q <= count_q + CW'(1);
        else if (w_pop && !w_push) count_q <= count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      pc_mem[wp_q]    <= pc_i;
      instr_mem[wp_q] <= instr_i;
      rd_mem[wp_q]    <= reg_addr_i;
      rdd_mem[wp_q]   <= (FILT_EN && !w_has_rd) ? '0 : reg_data_i;
      hasrd_mem[wp_q] <= w_has_rd;
      mwe_mem[wp_q]   <= mem_we_i;
      maddr_mem[wp_q] <= mem_addr_i;
      mdata_mem[wp_q] <= mem_data_i;
    end
  end

  assign out_valid_o    = (count_q != '0);
  assign out_pc_o       = out_valid_o ? pc_mem[rp_q]    : '0;
  assign out_instr_o    = out_valid_o ? instr_mem[rp_q] : '0;
  assign out_rd_o       = out_valid_o ? rd_mem[rp_q]    : '0;
  assign out_rd_data_o  = out_valid_o ? rdd_mem[rp_q]   : '0;
  assign out_has_rd_o   = out_valid_o && hasrd_mem[rp_q];
  assign out_mem_we_o   = out_valid_o && mwe_mem[rp_q];
  assign out_mem_addr_o = out_valid_o ? maddr_mem[rp_q] : '0;
  assign out_mem_data_o = out_valid_o ? mdata_mem[rp_q] : '0;
  assign count_o        = count_q;
  assign drop_cnt_o     = drop_q;
  assign instret_o      = instret_q;
  assign state_o        = state_q;

endmodule
`default_nettype wire

// File: doc/riscv_trace_buffer.md
Name: riscv_trace_buffer

Overview:
Synthesizable retire-trace capture buffer for the RV32I core family. Snoops the core's per-instruction commit port (update, pc, instr, rd write, memory write) and stores selected records in a parametrised FIFO. An optional PC trigger starts capture. Records drain through a valid/ready stream to a debug or host reader, replacing file-based trace logging with on-chip capture usable in silicon and in simulation.

Parameters:
XLEN, 32, datapath width of pc/data fields
DEPTH, 16, record entries; power of 2, >=2
WRAP, 0, 0 = stop-on-full (drop newest), 1 = overwrite oldest
FILTER_X0, 1, 1 = rd==0 records stored with has_rd=0, rd_data=0

Ports:
clk_i  in  1  clock
rstn_i  in  1  async active-low reset
update_i  in  1  one instruction retired this cycle
pc_i  in  XLEN  retired pc
instr_i  in  32  retired instruction word
reg_addr_i  in  5  rd index (0 = no write)
reg_data_i  in  XLEN  rd write data
mem_we_i  in  1  retired instr wrote memory
mem_addr_i  in  XLEN  store address
mem_data_i  in  XLEN  store data
enable_i  in  1  capture enable (level)
clear_i  in  1  sync flush of buffer and drop counter
trig_en_i  in  1  capture waits for PC trigger
trig_pc_i  in  XLEN  trigger pc
out_valid_o  out  1  head record available
out_ready_i  in  1  reader accepts head
out_pc_o, out_instr_o, out_rd_data_o, out_mem_addr_o, out_mem_data_o  out  XLEN/32/XLEN/XLEN/XLEN  head record fields
out_rd_o  out  5  head rd index
out_has_rd_o  out  1  head wrote a register
out_mem_we_o  out  1  head wrote memory
count_o  out  $clog2(DEPTH)+1  occupied entries
drop_cnt_o  out  16  records lost (saturating)
instret_o  out  64  total retires seen
state_o  out  2  IDLE=0, ARMED=1, CAPTURE=2

Behaviour:
- Reset (async, rstn_i low): state IDLE, pointers and count_o 0, out_valid_o 0, drop_cnt_o 0, instret_o 0. Storage contents don't-care; out_* fields read 0 while empty.
- instret_o increments on every update_i, independent of state, enable_i, clear_i. Wraps at 2^64.
- FSM (evaluated at each clk edge):
  IDLE: enable_i=1 -> ARMED if trig_en_i else CAPTURE.
  ARMED: update_i && pc_i==trig_pc_i -> push that record, go CAPTURE. Other retires ignored.
  CAPTURE: every update_i is a push request.
  ARMED/CAPTURE: enable_i=0 -> IDLE. Any push request in that same cycle is discarded. Buffer contents are kept.
- Push record: {pc_i, instr_i, reg_addr_i, reg_data_i, mem_we_i, mem_addr_i, mem_data_i}. has_rd = (reg_addr_i!=0). If FILTER_X0=1 and reg_addr_i==0, the rd_data field is stored as 0.
- Read: first-word-fall-through. out_valid_o = (count_o!=0). Fields come combinationally from the head entry. A pop occurs when out_valid_o && out_ready_i. A record pushed at edge N is visible from edge N onward (1-cycle latency). Reads operate in every state.
- Full push, WRAP=0: record dropped, drop_cnt_o +1 (saturates at 0xFFFF).
- Full push, WRAP=1, no pop same cycle: oldest entry overwritten, read pointer advances, count_o stays DEPTH, drop_cnt_o +1. Head fields may change while out_valid_o=1 and not accepted; readers in WRAP mode must tolerate this.
- Push and pop in the same cycle: both happen. count_o is unchanged and nothing is dropped, even when full.
- Pop while empty: ignored.
- clear_i: next edge empties the buffer (count_o=0) and zeroes drop_cnt_o. Same-cycle push and pop are discarded. State is unchanged. clear_i has priority over all other operations.
- Pointers: $clog2(DEPTH) bits, natural wrap.

Test Plan:
- Reset, enable_i=1, trig_en_i=0, 3 retires pc=0x80000000/04/08 with out_ready_i=0 -> count_o=3, head pc 0x80000000. Raise ready -> pcs drain in order, 1 per cycle, out_valid_o falls after the third pop.
- trig_en_i=1, trig_pc_i=0x80000010, retires 0x80000000..0x80000018 step 4 -> state ARMED->CAPTURE on 0x10. Buffer holds 0x10, 0x14, 0x18. instret_o=7.
- WRAP=0, DEPTH=16, 20 retires, ready=0 -> count_o=16, drop_cnt_o=4, head is the first pc. WRAP=1 with the same stimulus -> head is the 5th pc, drop_cnt_o=4.
- Full buffer, simultaneous update_i and pop for 5 cycles -> count_o stays 16, drop_cnt_o unchanged, order preserved.
- FILTER_X0=1: retire sw (reg_addr_i=0, reg_data_i=0xDEADBEEF, mem_we_i=1, mem_addr_i=0x100, mem_data_i=5) -> out_has_rd_o=0, out_rd_data_o=0, out_mem_we_o=1, out_mem_addr_o=0x100, out_mem_data_o=5.
- Assert rstn_i low mid-capture with count_o=7 -> all outputs zero immediately, not at the next edge. After release, state IDLE. Separately, clear_i pulsed with a concurrent push -> count_o=0 and drop_cnt_o=0 next cycle.
